// File: rtl/pcpu_mem_loader_pkg.sv
// Shared definitions for the CPU memory responder / program loader.
// Holds default header bytes, the loader FSM encoding and RAM target selects.
package pcpu_mem_loader_pkg;

  localparam logic [7:0] HDR_I_DEF = 8'h49;  // 'I' selects instruction RAM
  localparam logic [7:0] HDR_D_DEF = 8'h44;  // 'D' selects data RAM

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_HI    = 3'd3;
  localparam logic [2:0] ST_LO    = 3'd4;
  localparam logic [2:0] ST_WR    = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    COUNT = ST_COUNT,
    HI    = ST_HI,
    LO    = ST_LO,
    WR    = ST_WR
  } state_t;

  localparam logic T_IMEM = 1'b0;
  localparam logic T_DMEM = 1'b1;

endpackage

// File: rtl/pcpu_mem_loader_ram.sv
// Simple word RAM: one asynchronous read port, one synchronous write port.
// Ports:
//   clock        write clock
//   we/waddr/wdata  write port, sampled on rising edge
//   raddr/rdata  combinational read port
// Contents are deliberately not reset.
module pcpu_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcpu_mem_loader.sv
// Memory responder for the pipelined 16-bit CPU plus a byte-stream loader.
// Serves combinational instruction/data reads and clocked CPU stores, and lets a
// host stream words into either RAM while busy holds the CPU off.
// Ports:
//   clock, reset (async, active-low)
//   i_addr -> i_datain             instruction fetch (combinational)
//   d_addr, d_dataout, d_we -> d_datain   CPU load/store
//   ld_valid, ld_byte, ld_ready   host byte stream handshake
//   busy, done, err, collide      loader status
//
// state | meaning
// IDLE  | waiting for header byte (I or D target)
// ADDR  | waiting for start address byte
// COUNT | waiting for word count byte (0 = full RAM)
// HI    | waiting for high byte of next word
// LO    | waiting for low byte of next word
// WR    | writing assembled word, advancing pointer
module pcpu_mem_loader
  import pcpu_mem_loader_pkg::*;
#(
  parameter int         AW    = 8,
  parameter int         DW    = 16,
  parameter logic [7:0] HDR_I = HDR_I_DEF,
  parameter logic [7:0] HDR_D = HDR_D_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_datain,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dataout,
  input  logic          d_we,
  output logic [DW-1:0] d_datain,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          collide
);

  state_t        state, state_nxt;
  logic          target;
  logic [AW-1:0] wptr;
  logic [AW:0]   remain;
  logic [7:0]    hi_q, lo_q;
  logic          ld_fire;
  logic          ld_we;
  logic [AW:0]   count_ext;
  logic          last_word;

  logic          imem_we, dmem_ld_we;
  logic          dmem_we;
  logic [AW-1:0] dmem_waddr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] ld_word;

  assign ld_fire   = ld_valid && ld_ready;
  assign last_word = (remain == (AW+1)'(1));
  // A count byte of zero means a full-RAM load.
  assign count_ext = (ld_byte == 8'd0) ? {1'b1, {AW{1'b0}}} : (AW+1)'(ld_byte);
  assign ld_word   = DW'({hi_q, lo_q});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b1;
    busy      = 1'b1;
    ld_we     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (ld_valid && (ld_byte == HDR_I || ld_byte == HDR_D)) state_nxt = ADDR;
      end
      ADDR:  if (ld_valid) state_nxt = COUNT;
      COUNT: if (ld_valid) state_nxt = HI;
      HI:    if (ld_valid) state_nxt = LO;
      LO:    if (ld_valid) state_nxt = WR;
      WR: begin
        ld_ready  = 1'b0;
        ld_we     = 1'b1;
        state_nxt = last_word ? IDLE : HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target  <= T_IMEM;
      wptr    <= '0;
      remain  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      collide <= 1'b0;
    end else begin
      done <= (state == WR) && last_word;
      if (dmem_ld_we && d_we) collide <= 1'b1;
      case (state)
        IDLE: if (ld_fire) begin
          if (ld_byte == HDR_I)      target <= T_IMEM;
          else if (ld_byte == HDR_D) target <= T_DMEM;
          else                       err    <= 1'b1;
        end
        ADDR:  if (ld_fire) wptr   <= AW'(ld_byte);
        COUNT: if (ld_fire) remain <= count_ext;
        HI:    if (ld_fire) hi_q   <= ld_byte;
        LO:    if (ld_fire) lo_q   <= ld_byte;
        WR: begin
          wptr   <= wptr + 1'b1;
          remain <= remain - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = ld_we && (target == T_IMEM);
  assign dmem_ld_we = ld_we && (target == T_DMEM);

  // Loader owns the dmem write port in its WR cycle; a CPU store then is dropped.
  assign dmem_we    = dmem_ld_we || d_we;
  assign dmem_waddr = dmem_ld_we ? wptr    : d_addr;
  assign dmem_wdata = dmem_ld_we ? ld_word : d_dataout;

  pcpu_ram #(.AW(AW), .DW(DW)) u_imem (
    .clock (clock),
    .we    (imem_we),
    .waddr (wptr),
    .wdata (ld_word),
    .raddr (i_addr),
    .rdata (i_datain)
  );

  pcpu_ram #(.AW(AW), .DW(DW)) u_dmem (
    .clock (clock),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (d_addr),
    .rdata (d_datain)
  );

endmodule
